// File: rtl/dfs_lock_supervisor_if.sv
// Signal bundle between the DCM lock supervisor and its surroundings.
// slave: the supervisor side; master: the DCM / downstream side that observes it.
interface dfs_lock_supervisor_if;
  logic       LOCKED_IN;
  logic       DCM_RST_OUT;
  logic       SYS_RST_N_OUT;
  logic       READY_OUT;
  logic       FAIL_OUT;
  logic [3:0] RETRY_CNT_OUT;
  logic [7:0] LOSS_CNT_OUT;
  logic       CE_OUT;
  logic [2:0] DBG_STATE_OUT;

  modport slave (
    input  LOCKED_IN,
    output DCM_RST_OUT, SYS_RST_N_OUT, READY_OUT, FAIL_OUT,
    output RETRY_CNT_OUT, LOSS_CNT_OUT, CE_OUT, DBG_STATE_OUT
  );

  modport master (
    output LOCKED_IN,
    input  DCM_RST_OUT, SYS_RST_N_OUT, READY_OUT, FAIL_OUT,
    input  RETRY_CNT_OUT, LOSS_CNT_OUT, CE_OUT, DBG_STATE_OUT
  );
endinterface

// File: rtl/dfs_lock_supervisor.sv
// DCM_SP lock supervisor: reset sequencing, lock filtering, retry and re-acquire.
// Define DFS_SUP_CE_EN to build the fractional clock-enable generator; otherwise CE_OUT is 0.
module dfs_lock_supervisor #(
  parameter int RST_CYCLES   = 3,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_FILTER  = 16,
  parameter int MAX_RETRY    = 7,
  parameter int EN_INC       = 1,
  parameter int EN_MOD       = 10
) (
  input logic                   CLKIN_IN,
  input logic                   RST_N_IN,
  dfs_lock_supervisor_if.slave  bus
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int FL_W = $clog2(LOCK_FILTER + 1);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_FILTER = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, lock_s_q;
  logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [FL_W-1:0] flt_cnt_q, flt_cnt_d;
  logic [3:0]      retry_q, retry_d;
  logic [7:0]      loss_q, loss_d;
  logic            dcm_rst_q, dcm_rst_d;
  logic            sys_rst_n_q, sys_rst_n_d;
  logic            ready_q, ready_d;
  logic            fail_q, fail_d;
  logic            attempt_fail;

  // State register, counters, synchroniser and registered outputs
  always_ff @(posedge CLKIN_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      state_q     <= ST_RESET;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      flt_cnt_q   <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      dcm_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= bus.LOCKED_IN;
      lock_s_q    <= sync1_q;
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      flt_cnt_q   <= flt_cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      dcm_rst_q   <= dcm_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  // Next-state logic; counters not owned by the current state fall back to zero
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = '0;
    to_cnt_d     = '0;
    flt_cnt_d    = '0;
    retry_d      = retry_q;
    loss_d       = loss_q;
    attempt_fail = 1'b0;
    case (state_q)
      ST_RESET: begin
        rst_cnt_d = rst_cnt_q + 1'b1;
        if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
          rst_cnt_d = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (lock_s_q)                                   state_d = ST_FILTER;
        else if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1))   attempt_fail = 1'b1;
      end
      ST_FILTER: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (lock_s_q) flt_cnt_d = flt_cnt_q + 1'b1;
        // Filter completion outranks a timeout landing on the same cycle
        if (lock_s_q && flt_cnt_q == FL_W'(LOCK_FILTER - 1)) begin
          state_d = ST_RUN;
          retry_d = '0;
        end else if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
          attempt_fail = 1'b1;
        end else if (!lock_s_q) begin
          state_d = ST_WAIT;
        end
      end
      ST_RUN: begin
        retry_d = '0;
        if (!lock_s_q) begin
          state_d = ST_RESET;
          if (loss_q != 8'hFF) loss_d = loss_q + 1'b1;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_RESET;
    endcase
    if (attempt_fail) begin
      if (retry_q == 4'(MAX_RETRY)) begin
        state_d = ST_FAIL;
      end else begin
        state_d = ST_RESET;
        retry_d = retry_q + 1'b1;
      end
    end
  end

  // Outputs decoded from the next state so they change on the same edge as the state
  always_comb begin
    dcm_rst_d   = (state_d == ST_RESET) || (state_d == ST_FAIL);
    sys_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

`ifdef DFS_SUP_CE_EN
  localparam int AW = $clog2(2 * EN_MOD);
  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_sum;
  logic          ce_q;

  assign acc_sum = acc_q + AW'(EN_INC);

  always_ff @(posedge CLKIN_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else if (state_q == ST_RUN) begin
      if (acc_sum >= AW'(EN_MOD)) begin
        acc_q <= acc_sum - AW'(EN_MOD);
        ce_q  <= 1'b1;
      end else begin
        acc_q <= acc_sum;
        ce_q  <= 1'b0;
      end
    end else begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end
  end

  assign bus.CE_OUT = ce_q;
`else
  assign bus.CE_OUT = 1'b0;
`endif

  assign bus.DCM_RST_OUT   = dcm_rst_q;
  assign bus.SYS_RST_N_OUT = sys_rst_n_q;
  assign bus.READY_OUT     = ready_q;
  assign bus.FAIL_OUT      = fail_q;
  assign bus.RETRY_CNT_OUT = retry_q;
  assign bus.LOSS_CNT_OUT  = loss_q;
  assign bus.DBG_STATE_OUT = state_q;

endmodule

// File: tb/tb_dfs_lock_supervisor.sv
// Bench for dfs_lock_supervisor: dut_a (defaults, EN_INC=3/EN_MOD=8) covers lock, glitch,
// loss and enable rate; dut_b (LOCK_TIMEOUT=20) covers retry exhaustion and FAIL.
module tb_dfs_lock_supervisor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dfs_lock_supervisor_if if_a ();
  dfs_lock_supervisor_if if_b ();

  dfs_lock_supervisor #(.EN_INC(3), .EN_MOD(8)) dut_a (
    .CLKIN_IN (clk),
    .RST_N_IN (rst_n),
    .bus      (if_a)
  );

  dfs_lock_supervisor #(.LOCK_TIMEOUT(20)) dut_b (
    .CLKIN_IN (clk),
    .RST_N_IN (rst_n),
    .bus      (if_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %0d with no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
      end
    end
  endtask

  task automatic expect_chk(input string tag, input logic [15:0] exp, input logic [15:0] obs);
    exp_q.push_back(exp);
    check(tag, obs);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    if_a.LOCKED_IN = 1'b0;
    if_b.LOCKED_IN = 1'b0;
    #1;
    expect_chk("rst_dcm_rst",   1, if_a.DCM_RST_OUT);
    expect_chk("rst_sys_rst_n", 0, if_a.SYS_RST_N_OUT);
    expect_chk("rst_ready",     0, if_a.READY_OUT);
    expect_chk("rst_fail",      0, if_a.FAIL_OUT);
    expect_chk("rst_retry",     0, if_a.RETRY_CNT_OUT);
    expect_chk("rst_loss",      0, if_a.LOSS_CNT_OUT);
    expect_chk("rst_ce",        0, if_a.CE_OUT);
    expect_chk("rst_b_fail",    0, if_b.FAIL_OUT);
    expect_chk("rst_b_retry",   0, if_b.RETRY_CNT_OUT);
    step(3);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int dcm_pulses;
    int fail_edge;
    logic prev_dcm;
    logic [3:0] prev_retry;
    int left;

    // Clean lock on dut_a
    @(posedge clk); #1;
    apply_reset();
    step(2);
    expect_chk("clean_dcm_high_2", 1, if_a.DCM_RST_OUT);
    step(1);
    expect_chk("clean_dcm_low_3", 0, if_a.DCM_RST_OUT);
    step(97);
    if_a.LOCKED_IN = 1'b1;
    step(18);
    expect_chk("clean_sys_early", 0, if_a.SYS_RST_N_OUT);
    expect_chk("clean_ce_pre_run", 0, if_a.CE_OUT);
    step(1);
    expect_chk("clean_sys_release", 1, if_a.SYS_RST_N_OUT);
    expect_chk("clean_ready", 1, if_a.READY_OUT);
    expect_chk("clean_retry", 0, if_a.RETRY_CNT_OUT);
    expect_chk("clean_dcm", 0, if_a.DCM_RST_OUT);

    // Enable rate: queue the expected CE sequence, then compare as cycles elapse
    acc = 0;
    for (int n = 1; n <= 16; n++) begin
`ifdef DFS_SUP_CE_EN
      acc += 3;
      if (acc >= 8) begin
        acc -= 8;
        exp_q.push_back(16'd1);
      end else begin
        exp_q.push_back(16'd0);
      end
`else
      exp_q.push_back(16'd0);
`endif
    end
    for (int n = 1; n <= 16; n++) begin
      step(1);
      check("ce_pattern", if_a.CE_OUT);
    end

    // Loss of lock in RUN
    if_a.LOCKED_IN = 1'b0;
    step(2);
    expect_chk("loss_sys_still_high", 1, if_a.SYS_RST_N_OUT);
    step(1);
    expect_chk("loss_sys_low", 0, if_a.SYS_RST_N_OUT);
    expect_chk("loss_ready_low", 0, if_a.READY_OUT);
    expect_chk("loss_cnt", 1, if_a.LOSS_CNT_OUT);
    expect_chk("loss_dcm_resequence", 1, if_a.DCM_RST_OUT);
    step(2);
    if_a.LOCKED_IN = 1'b1;
    step(18);
    expect_chk("loss_relock_early", 0, if_a.SYS_RST_N_OUT);
    expect_chk("loss_ce_idle", 0, if_a.CE_OUT);
    step(1);
    expect_chk("loss_relock_release", 1, if_a.SYS_RST_N_OUT);
    expect_chk("loss_cnt_held", 1, if_a.LOSS_CNT_OUT);

    // Glitchy lock: filter must restart after the dropout
    apply_reset();
    expect_chk("glitch_loss_cleared", 0, if_a.LOSS_CNT_OUT);
    step(20);
    if_a.LOCKED_IN = 1'b1;
    step(10);
    if_a.LOCKED_IN = 1'b0;
    step(2);
    expect_chk("glitch_sys_low", 0, if_a.SYS_RST_N_OUT);
    if_a.LOCKED_IN = 1'b1;
    step(18);
    expect_chk("glitch_sys_early", 0, if_a.SYS_RST_N_OUT);
    step(1);
    expect_chk("glitch_sys_release", 1, if_a.SYS_RST_N_OUT);

    // Retry exhaustion on dut_b (each attempt is 3 reset + 20 wait cycles)
    apply_reset();
    for (int r = 1; r <= 7; r++) exp_q.push_back(16'(r));
    dcm_pulses = 1;
    fail_edge  = 0;
    prev_dcm   = 1'b1;
    prev_retry = 4'd0;
    for (int e = 1; e <= 300; e++) begin
      step(1);
      if (if_b.DCM_RST_OUT && !prev_dcm && !if_b.FAIL_OUT) dcm_pulses++;
      prev_dcm = if_b.DCM_RST_OUT;
      if (if_b.RETRY_CNT_OUT !== prev_retry) begin
        check("retry_step", if_b.RETRY_CNT_OUT);
        prev_retry = if_b.RETRY_CNT_OUT;
      end
      if (if_b.FAIL_OUT && fail_edge == 0) fail_edge = e;
    end
    left = exp_q.size();
    exp_q.delete();
    expect_chk("retry_steps_missing", 0, left);
    expect_chk("retry_dcm_pulses", 8, dcm_pulses);
    expect_chk("retry_fail_edge", 184, fail_edge);
    expect_chk("fail_flag", 1, if_b.FAIL_OUT);
    expect_chk("fail_dcm_rst", 1, if_b.DCM_RST_OUT);
    expect_chk("fail_sys_rst_n", 0, if_b.SYS_RST_N_OUT);
    expect_chk("fail_retry", 7, if_b.RETRY_CNT_OUT);
    if_b.LOCKED_IN = 1'b1;
    step(50);
    expect_chk("fail_held", 1, if_b.FAIL_OUT);
    expect_chk("fail_held_sys", 0, if_b.SYS_RST_N_OUT);

    rst_n = 1'b0;
    #1;
    expect_chk("fail_cleared_by_reset", 0, if_b.FAIL_OUT);
    expect_chk("fail_retry_cleared", 0, if_b.RETRY_CNT_OUT);
    step(2);
    rst_n = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dfs_lock_supervisor.md
# dfs_lock_supervisor

Supervises a DCM_SP frequency synthesiser: it sequences the DCM reset, qualifies and filters its LOCKED output, retries failed lock attempts and holds the downstream system in reset until the synthesised clock is stable. It also re-acquires lock automatically after a loss of lock and emits a parametrised fractional clock-enable for downstream sampling logic. It runs on the free-running input clock (the 10 MHz board clock feeding the DCM), never on the synthesised clock, so it keeps working while the DCM is unlocked.

## Interface
- RST_CYCLES, 3: cycles DCM_RST_OUT is held high per attempt (≥3 required by DCM_SP).
- LOCK_TIMEOUT, 50000: cycles to wait for lock before retrying (5 ms at 10 MHz).
- LOCK_FILTER, 16: consecutive synchronised-lock cycles required before release.
- MAX_RETRY, 7: failed attempts tolerated before FAIL; must be ≤15.
- EN_INC, 1: fractional-enable increment; 1 ≤ EN_INC ≤ EN_MOD.
- EN_MOD, 10: fractional-enable modulus; CE rate = f(CLKIN_IN)·EN_INC/EN_MOD.

Ports:
- CLKIN_IN  in  1  single clock, input reference clock.
- RST_N_IN  in  1  reset; asynchronous, active-low.
- LOCKED_IN  in  1  DCM LOCKED, asynchronous to CLKIN_IN.
- DCM_RST_OUT  out  1  to DCM RST, active-high.
- SYS_RST_N_OUT  out  1  downstream reset, active-low.
- READY_OUT  out  1  high in RUN.
- FAIL_OUT  out  1  high in FAIL.
- RETRY_CNT_OUT  out  4  failed attempts in the current acquisition.
- LOSS_CNT_OUT  out  8  saturating count of lock losses while in RUN.
- CE_OUT  out  1  fractional clock enable, one cycle wide.

## Operation
- LOCKED_IN passes through a 2-flop synchroniser to lock_s; only lock_s is used.
- States: RESET, WAIT, FILTER, RUN, FAIL.
- RESET: DCM_RST_OUT=1 for exactly RST_CYCLES cycles, then WAIT. The timeout and filter counters clear on entry.
- WAIT: the timeout counter increments each cycle.
  - lock_s=1 → FILTER.
  - Counter reaches LOCK_TIMEOUT−1 with lock_s=0 → attempt fails:
    - if RETRY_CNT_OUT==MAX_RETRY → FAIL;
    - else RETRY_CNT_OUT+1 → RESET.
- FILTER: the timeout counter keeps running; the filter counter increments while lock_s=1.
  - lock_s=0 → WAIT, filter counter cleared.
  - Filter count reaches LOCK_FILTER → RUN.
  - If timeout expiry and filter completion occur in the same cycle, the filter completion wins.
- RUN: READY_OUT=1, SYS_RST_N_OUT=1, RETRY_CNT_OUT cleared.
  - lock_s=0 → RESET, LOSS_CNT_OUT+1 (saturates at 255).
  - SYS_RST_N_OUT and READY_OUT drop on the next edge.
- FAIL: terminal until RST_N_IN asserts. DCM_RST_OUT=1, FAIL_OUT=1, SYS_RST_N_OUT=0.
- Fractional enable:
  - In RUN only: acc ← acc+EN_INC; if the sum ≥ EN_MOD, then acc ← sum−EN_MOD and CE_OUT=1.
  - Outside RUN: acc=0, CE_OUT=0.
  - acc width is $clog2(2·EN_MOD); no overflow is possible.
- All outputs are registered.

## Timing
- Reset values: state RESET, DCM_RST_OUT=1, SYS_RST_N_OUT=0, READY_OUT=0, FAIL_OUT=0, RETRY_CNT_OUT=0, LOSS_CNT_OUT=0, CE_OUT=0, acc=0, synchroniser=0.
- After RST_N_IN deasserts, DCM_RST_OUT stays high for RST_CYCLES edges.
- LOCKED_IN rise to FILTER entry: 3 edges (2 sync + 1 state).
- Release: SYS_RST_N_OUT rises LOCK_FILTER edges after FILTER entry.
- LOCKED_IN fall in RUN to SYS_RST_N_OUT low: 3 edges.
- First CE_OUT: at the earliest, the first RUN cycle's edge + 1.
- Asserting RST_N_IN mid-operation returns all outputs to their reset values immediately, including LOSS_CNT_OUT.

## Configuration
- DFS_SUP_CE_EN defined: the fractional-enable generator is built as described.
- DFS_SUP_CE_EN undefined: no accumulator is synthesised; CE_OUT is constant 0. EN_INC and EN_MOD are ignored.

## Test plan
- **Clean lock** (defaults): LOCKED_IN rises 100 cycles after reset →
  - DCM_RST_OUT high for 3 cycles;
  - SYS_RST_N_OUT/READY_OUT high 3+16 edges after the LOCKED_IN rise;
  - RETRY_CNT_OUT=0.
- **Glitchy lock**: LOCKED_IN high 10 cycles, low 2, then high →
  - FILTER restarts;
  - release 16 cycles after the second synchronised rise.
- **Retry/fail**: LOCK_TIMEOUT=20, LOCKED_IN held 0 →
  - RETRY_CNT_OUT steps 1..7;
  - DCM_RST_OUT pulses 8 times total, then FAIL_OUT=1;
  - state held until RST_N_IN.
- **Loss in RUN**: drop LOCKED_IN for 5 cycles, then restore →
  - SYS_RST_N_OUT low after 3 edges;
  - LOSS_CNT_OUT=1;
  - full resequence and re-release.
- **Enable rate** (EN_INC=3, EN_MOD=8, DFS_SUP_CE_EN defined) → exactly 3 CE_OUT pulses per 8 RUN cycles, pattern repeating every 8.
- **Macro off**: rerun the clean-lock test without DFS_SUP_CE_EN → CE_OUT stays 0 throughout; sequencing is identical.
